// File: rtl/bsk_prd_pkg.sv
// Shared constants for the PRD bus side: command width, idle command word and the
// default timing of the command input conditioner.
package bsk_prd_pkg;

    localparam int COM_WIDTH = 16;
    localparam logic [COM_WIDTH-1:0] COM_DEFAULT = 16'hFFFF;
    localparam int CLOCK_IN = 2_000_000;

    // 20 clk at 2 MHz gives a 10 us sample period; 10 agreeing samples accept a change.
    localparam int DEF_SAMPLE_DIV = 20;
    localparam int DEF_FILT_SAMPLES = 10;

    // Counter must hold 0..FILT_SAMPLES-1 without ever wrapping.
    function automatic int cnt_width(input int filt_samples);
        return (filt_samples < 2) ? 1 : $clog2(filt_samples + 1);
    endfunction

    function automatic int presc_width(input int sample_div);
        return (sample_div < 2) ? 1 : $clog2(sample_div);
    endfunction

endpackage

// File: rtl/bsk_com_debounce_ch.sv
// One command channel: two-FF synchroniser, run-length counter of differing sample
// ticks, and the accepted (filtered) state bit.
module bsk_com_debounce_ch
    import bsk_prd_pkg::*;
#(
    parameter int   FILT_SAMPLES = DEF_FILT_SAMPLES,
    parameter logic RESET_VAL    = 1'b1
) (
    input  logic clk,
    input  logic iRes,
    input  logic com_i,
    input  logic tick_i,
    output logic state_o
);

    localparam int CW = cnt_width(FILT_SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_SAMPLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          state_q;
    logic          state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= com_i;
            sync2_q <= sync1_q;
        end
    end

    // A single agreeing tick restarts the run; the last differing tick commits the change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            if (sync2_q == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            state_q <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/bsk_prd_com_filter.sv
// Command input conditioner in front of the PRD bus interface: per-channel debounce,
// freezable output word, change pulse and sticky change flag for the CPU.
module bsk_prd_com_filter
    import bsk_prd_pkg::*;
#(
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int FILT_SAMPLES = DEF_FILT_SAMPLES
) (
    input  logic                 clk,
    input  logic                 iRes,
    input  logic [COM_WIDTH-1:0] iCom,
    input  logic                 iFreeze,
    input  logic                 iEventClr,
    output logic [COM_WIDTH-1:0] oCom,
    output logic                 oChanged,
    output logic                 oEvent
);

    localparam int PW = presc_width(SAMPLE_DIV);
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(SAMPLE_DIV - 1);

    logic [PW-1:0]        presc_q;
    logic [PW-1:0]        presc_d;
    logic                 tick;
    logic [COM_WIDTH-1:0] state_w;
    logic [COM_WIDTH-1:0] com_q;
    logic [COM_WIDTH-1:0] com_d;
    logic                 changed_q;
    logic                 changed_d;
    logic                 event_q;
    logic                 event_d;

    // First tick lands on clk edge SAMPLE_DIV after reset release.
    assign tick = (presc_q == '0);

    always_comb begin
        presc_d = presc_q - 1'b1;
        if (tick) begin
            presc_d = PRESC_RELOAD;
        end
    end

    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            presc_q <= PRESC_RELOAD;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < COM_WIDTH; g++) begin : g_ch
        bsk_com_debounce_ch #(
            .FILT_SAMPLES (FILT_SAMPLES),
            .RESET_VAL    (COM_DEFAULT[g])
        ) u_ch (
            .clk     (clk),
            .iRes    (iRes),
            .com_i   (iCom[g]),
            .tick_i  (tick),
            .state_o (state_w[g])
        );
    end

    // Hold contract: while iFreeze=1 oCom is guaranteed stable for the bus reader; filtering
    // keeps running, and the word reloads from the filtered state on the first clk after release.
    always_comb begin
        com_d     = iFreeze ? com_q : state_w;
        changed_d = (com_d != com_q);
        event_d   = changed_q | (event_q & ~iEventClr);
    end

    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            com_q     <= COM_DEFAULT;
            changed_q <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            com_q     <= com_d;
            changed_q <= changed_d;
            event_q   <= event_d;
        end
    end

    assign oCom     = com_q;
    assign oChanged = changed_q;
    assign oEvent   = event_q;

endmodule

// File: tb/tb_bsk_prd_com_filter.sv
// Directed bench for bsk_prd_com_filter with default timing (SAMPLE_DIV=20, FILT_SAMPLES=10).
module tb_bsk_prd_com_filter;

  logic        clk;
  logic        iRes;
  logic [15:0] iCom;
  logic        iFreeze;
  logic        iEventClr;
  logic [15:0] oCom;
  logic        oChanged;
  logic        oEvent;

  int tests_run;
  int tests_failed;
  int cyc;
  int chg_cnt;
  int n_bad;

  bsk_prd_com_filter dut (
    .clk       (clk),
    .iRes      (iRes),
    .iCom      (iCom),
    .iFreeze   (iFreeze),
    .iEventClr (iEventClr),
    .oCom      (oCom),
    .oChanged  (oChanged),
    .oEvent    (oEvent)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // oChanged pulses seen since the last reset release
  always @(negedge clk) begin
    if (iRes && oChanged === 1'b1) chg_cnt++;
  end

  // driver tasks; cyc = clk edges since reset release, sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input logic [15:0] com, input logic frz);
    iRes = 1'b0;
    iCom = com;
    iFreeze = frz;
    iEventClr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    iRes = 1'b1;
    cyc = 0;
    chg_cnt = 0;
  endtask

  // all lines low through reset: the filtered word reaches 0000 on edge 201
  task automatic test_reset();
    iRes = 1'b0;
    iCom = 16'h0000;
    iFreeze = 1'b0;
    iEventClr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (oCom !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL reset_ocom: got %h expected ffff", oCom);
    end
    tests_run++;
    if (oEvent !== 1'b0 || oChanged !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got event=%b changed=%b expected 0 0", oEvent, oChanged);
    end
    iRes = 1'b1;
    cyc = 0;
    chg_cnt = 0;
    run_to(200);
    tests_run++;
    if (oCom !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL reset_edge200: got %h expected ffff", oCom);
    end
    step();
    tests_run++;
    if (oCom !== 16'h0000 || oChanged !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_edge201: got %h chg=%b expected 0000 chg=1", oCom, oChanged);
    end
    run_to(260);
    tests_run++;
    if (chg_cnt !== 1 || oEvent !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_single_pulse: got pulses=%0d event=%b expected 1 1", chg_cnt, oEvent);
    end
  endtask

  // 150-clk low glitch on bit 0 must be rejected
  task automatic test_glitch();
    do_reset(16'hFFFF, 1'b0);
    n_bad = 0;
    while (cyc < 400) begin
      iCom[0] = (cyc >= 10 && cyc < 160) ? 1'b0 : 1'b1;
      step();
      if (oCom !== 16'hFFFF) n_bad++;
    end
    tests_run++;
    if (n_bad !== 0 || chg_cnt !== 0) begin
      tests_failed++;
      $display("FAIL glitch: got bad_cycles=%0d pulses=%0d expected 0 0", n_bad, chg_cnt);
    end
  endtask

  // bit 3 held low from edge 17 (last phase that still catches tick 20); bit 5 chatters
  task automatic test_steady();
    do_reset(16'hFFFF, 1'b0);
    n_bad = 0;
    while (cyc < 400) begin
      iCom[3] = (cyc >= 17) ? 1'b0 : 1'b1;
      iCom[5] = (cyc >= 17) ? (((cyc - 17) / 20) % 2 == 1) : 1'b1;
      step();
      if (oCom[5] !== 1'b1) n_bad++;
      if (cyc == 200) begin
        tests_run++;
        if (oCom !== 16'hFFFF) begin
          tests_failed++;
          $display("FAIL steady_edge200: got %h expected ffff", oCom);
        end
      end
      if (cyc == 201) begin
        tests_run++;
        if (oCom !== 16'hFFF7) begin
          tests_failed++;
          $display("FAIL steady_edge201: got %h expected fff7", oCom);
        end
      end
    end
    tests_run++;
    if (n_bad !== 0 || chg_cnt !== 1 || oCom !== 16'hFFF7) begin
      tests_failed++;
      $display("FAIL steady_chatter: got bad=%0d pulses=%0d ocom=%h expected 0 1 fff7",
               n_bad, chg_cnt, oCom);
    end
  endtask

  // applied one edge later than above: misses tick 20, accepted on tick 220
  task automatic test_late_phase();
    do_reset(16'hFFFF, 1'b0);
    run_to(18);
    iCom[4] = 1'b0;
    run_to(220);
    tests_run++;
    if (oCom !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL late_edge220: got %h expected ffff", oCom);
    end
    step();
    tests_run++;
    if (oCom !== 16'hFFEF) begin
      tests_failed++;
      $display("FAIL late_edge221: got %h expected ffef", oCom);
    end
  endtask

  task automatic test_freeze();
    do_reset(16'hFFFF, 1'b1);
    iCom[15] = 1'b0;
    n_bad = 0;
    while (cyc < 400) begin
      step();
      if (oCom !== 16'hFFFF) n_bad++;
    end
    tests_run++;
    if (n_bad !== 0 || chg_cnt !== 0) begin
      tests_failed++;
      $display("FAIL freeze_hold: got bad=%0d pulses=%0d expected 0 0", n_bad, chg_cnt);
    end
    iFreeze = 1'b0;
    step();
    tests_run++;
    if (oCom !== 16'h7FFF || oChanged !== 1'b1) begin
      tests_failed++;
      $display("FAIL freeze_release: got %h chg=%b expected 7fff chg=1", oCom, oChanged);
    end
    run_to(410);
    tests_run++;
    if (chg_cnt !== 1) begin
      tests_failed++;
      $display("FAIL freeze_pulses: got %0d expected 1", chg_cnt);
    end
  endtask

  // bit 1 accepted low then back high during freeze: no update, no pulse on release
  task automatic test_freeze_return();
    do_reset(16'hFFFF, 1'b1);
    iCom[1] = 1'b0;
    run_to(220);
    iCom[1] = 1'b1;
    run_to(450);
    iFreeze = 1'b0;
    run_to(460);
    tests_run++;
    if (oCom !== 16'hFFFF || chg_cnt !== 0 || oEvent !== 1'b0) begin
      tests_failed++;
      $display("FAIL freeze_return: got %h pulses=%0d event=%b expected ffff 0 0",
               oCom, chg_cnt, oEvent);
    end
  endtask

  task automatic test_event();
    do_reset(16'hFFFF, 1'b0);
    iCom[2] = 1'b0;
    run_to(201);
    tests_run++;
    if (oChanged !== 1'b1 || oEvent !== 1'b0) begin
      tests_failed++;
      $display("FAIL event_pre: got chg=%b event=%b expected 1 0", oChanged, oEvent);
    end
    iEventClr = 1'b1;
    step();
    iEventClr = 1'b0;
    tests_run++;
    if (oEvent !== 1'b1 || oChanged !== 1'b0) begin
      tests_failed++;
      $display("FAIL event_set_wins: got event=%b chg=%b expected 1 0", oEvent, oChanged);
    end
    step();
    tests_run++;
    if (oEvent !== 1'b1) begin
      tests_failed++;
      $display("FAIL event_sticky: got %b expected 1", oEvent);
    end
    iEventClr = 1'b1;
    step();
    iEventClr = 1'b0;
    run_to(210);
    tests_run++;
    if (oEvent !== 1'b0) begin
      tests_failed++;
      $display("FAIL event_clear: got %b expected 0", oEvent);
    end
  endtask

  // reset after 100 clk of a pending change: acceptance restarts from zero
  task automatic test_reset_mid();
    do_reset(16'hFFFF, 1'b0);
    iCom[8] = 1'b0;
    run_to(100);
    iRes = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (oCom !== 16'hFFFF || oChanged !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_state: got %h chg=%b expected ffff 0", oCom, oChanged);
    end
    iRes = 1'b1;
    cyc = 0;
    chg_cnt = 0;
    run_to(200);
    tests_run++;
    if (oCom !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL mid_edge200: got %h expected ffff", oCom);
    end
    step();
    tests_run++;
    if (oCom !== 16'hFEFF) begin
      tests_failed++;
      $display("FAIL mid_edge201: got %h expected feff", oCom);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    chg_cnt = 0;
    n_bad = 0;
    iRes = 1'b0;
    iCom = 16'hFFFF;
    iFreeze = 1'b0;
    iEventClr = 1'b0;
    test_reset();
    test_glitch();
    test_steady();
    test_late_phase();
    test_freeze();
    test_freeze_return();
    test_event();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
